reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/hazard_pkg.sv | 9 +
 rtl/reg_scoreboard_sb_entry.sv | 45 ++++
 rtl/reg_scoreboard.sv | 82 ++++++++
 tb/tb_reg_scoreboard.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the register scoreboard.
// No ports; the counter-width default is overridable per instance.
package hazard_pkg;

    localparam int REG_ADDR_W    = 4;
    localparam int NUM_REGS      = 16;
    localparam int CNT_W_DEFAULT = 2;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// sb_entry: one saturating up/down in-flight write counter.
// Ports: clk, rst, inc, dec -> count, nonzero (registered), full.
module sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             full
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic             do_inc;
    logic             do_dec;
    logic [CNT_W-1:0] cnt_nxt;

    assign full   = (count == MAX);
    assign do_inc = inc && !full;
    // A retire against an empty counter is an error, not a release.
    assign do_dec = dec && (count != '0);

    always_comb begin
        cnt_nxt = count;
        if (do_inc && !do_dec)
            cnt_nxt = count + 1'b1;
        else if (do_dec && !do_inc)
            cnt_nxt = count - 1'b1;
    end

    // nonzero is registered from the next value so it tracks count exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            nonzero <= 1'b0;
        end else begin
            count   <= cnt_nxt;
            nonzero <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write tracking with WB bypass.
// Ports: issue_* / src* / two_src in, wb_valid / wb_dest in;
// hazard, issue_ready (comb), pending_mask, wb_err, stall_cycles (reg).
// Optional: define SCOREBOARD_STATS_EN to count stalled issue cycles.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wb_en,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  two_src,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  hazard,
    output logic                  issue_ready,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  wb_err,
    output logic [15:0]           stall_cycles
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] nz;
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] eff_nz;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        logic hit;
        assign hit = wb_valid && (wb_dest == REG_ADDR_W'(r));
        // Same-cycle retire releases one pending write early.
        assign eff_nz[r] = hit ? (cnt[r] > CNT_W'(1))
                               : (cnt[r] != '0);
        assign inc[r] = issue_ready && issue_wb_en &&
                        (issue_dest == REG_ADDR_W'(r));
        assign dec[r] = hit;

        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[r]),
            .dec     (dec[r]),
            .count   (cnt[r]),
            .nonzero (nz[r]),
            .full    (full[r])
        );
    end

    assign hazard = issue_valid &&
                    (eff_nz[src1] || (two_src && eff_nz[src2]));

    assign issue_ready = issue_valid && !hazard &&
                         !(issue_wb_en && full[issue_dest]);

    assign pending_mask = nz;

    always_ff @(posedge clk) begin
        if (rst)
            wb_err <= 1'b0;
        else if (wb_valid && !nz[wb_dest])
            wb_err <= 1'b1;
    end

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (issue_valid && !issue_ready &&
                 (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard (default CNT_W = 2).
// Directed scenarios plus randomized traffic against a count model.
module tb_reg_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic        hazard;
    logic        issue_ready;
    logic [15:0] pending_mask;
    logic        wb_err;
    logic [15:0] stall_cycles;

    int tests  = 0;
    int errors = 0;

    int cnt [16];
    bit m_err;
    int m_stalls;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_wb_en  (issue_wb_en),
        .issue_dest   (issue_dest),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .hazard       (hazard),
        .issue_ready  (issue_ready),
        .pending_mask (pending_mask),
        .wb_err       (wb_err),
        .stall_cycles (stall_cycles)
    );

    // ---------------- reference model ----------------
    function automatic bit m_busy(int r);
        int e;
        e = cnt[r];
        if (wb_valid && int'(wb_dest) == r) e = e - 1;
        return e > 0;
    endfunction

    function automatic bit m_hazard();
        return issue_valid &&
               (m_busy(int'(src1)) || (two_src && m_busy(int'(src2))));
    endfunction

    function automatic bit m_ready();
        return issue_valid && !m_hazard() &&
               !(issue_wb_en && cnt[issue_dest] == MAXC);
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] m;
        m = '0;
        for (int r = 0; r < 16; r++) m[r] = (cnt[r] != 0);
        return m;
    endfunction

    task automatic tick();
        bit rdy;
        bit stalled;
        rdy     = m_ready();
        stalled = issue_valid && !rdy;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 16; r++) cnt[r] = 0;
            m_err    = 0;
            m_stalls = 0;
        end else begin
            if (wb_valid) begin
                if (cnt[wb_dest] == 0) m_err = 1;
                else cnt[wb_dest] = cnt[wb_dest] - 1;
            end
            if (rdy && issue_wb_en) cnt[issue_dest] = cnt[issue_dest] + 1;
`ifdef SCOREBOARD_STATS_EN
            if (stalled && m_stalls < 65535) m_stalls = m_stalls + 1;
`endif
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; issue_valid = 0; issue_wb_en = 0; issue_dest = 0;
        src1 = 0; src2 = 0; two_src = 0; wb_valid = 0; wb_dest = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic issue(input logic [3:0] d, input logic wb,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic ts);
        issue_valid = 1; issue_wb_en = wb; issue_dest = d;
        src1 = s1; src2 = s2; two_src = ts;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        issue(4'd1, 1, 0, 0, 0);
        wb_valid = 1; wb_dest = 4'd2;
        rst = 1;
        tick();
        idle();
        #1;
        tests++;
        if (pending_mask !== 16'h0) begin
            errors++;
            $display("FAIL reset_mask got %h want 0000", pending_mask);
        end
        tests++;
        if (wb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", wb_err);
        end
        tests++;
        if (stall_cycles !== 16'h0) begin
            errors++;
            $display("FAIL reset_stall got %0d want 0", stall_cycles);
        end
        tests++;
        if (hazard !== 1'b0 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got hz=%b rdy=%b want 0 0",
                     hazard, issue_ready);
        end
    endtask

    task automatic test_basic_hazard();
        do_reset();
        issue(4'd3, 1, 0, 0, 0);
        #1;
        tests++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_issue_ready got %b want 1", issue_ready);
        end
        tick();
        idle();
        tests++;
        if (pending_mask !== 16'h0008) begin
            errors++;
            $display("FAIL basic_mask got %h want 0008", pending_mask);
        end
        issue(4'd0, 0, 4'd3, 0, 0);
        #1;
        tests++;
        if (hazard !== 1'b1 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_raw got hz=%b rdy=%b want 1 0",
                     hazard, issue_ready);
        end
        tick();
        idle();
    endtask

    // Relies on counter[3]==1 left by test_basic_hazard.
    task automatic test_bypass();
        issue(4'd0, 0, 4'd3, 0, 0);
        wb_valid = 1; wb_dest = 4'd3;
        #1;
        tests++;
        if (hazard !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL bypass got hz=%b rdy=%b want 0 1",
                     hazard, issue_ready);
        end
        tick();
        idle();
        tests++;
        if (pending_mask[3] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_mask got %h want bit3 clear", pending_mask);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(4'd5, 1, 0, 0, 0);
            #1;
            tests++;
            if (issue_ready !== (i < 3)) begin
                errors++;
                $display("FAIL sat_ready%0d got %b want %b",
                         i, issue_ready, (i < 3));
            end
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_dest = 4'd5;
            tick();
            tests++;
            if (pending_mask[5] !== (i < 2)) begin
                errors++;
                $display("FAIL sat_retire%0d got %h want bit5=%b",
                         i, pending_mask, (i < 2));
            end
        end
        idle();
        tests++;
        if (wb_err !== 1'b0) begin
            errors++;
            $display("FAIL sat_err got %b want 0", wb_err);
        end
    endtask

    task automatic test_wb_err();
        do_reset();
        wb_valid = 1; wb_dest = 4'd7;
        tick();
        idle();
        tests++;
        if (wb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b want 1", wb_err);
        end
        tick(); tick();
        tests++;
        if (wb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", wb_err);
        end
        do_reset();
        tests++;
        if (wb_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", wb_err);
        end
    endtask

    task automatic test_two_src();
        do_reset();
        issue(4'd4, 1, 0, 0, 0);
        tick();
        issue(4'd0, 0, 4'd0, 4'd4, 0);
        #1;
        tests++;
        if (hazard !== 1'b0) begin
            errors++;
            $display("FAIL src2_off got %b want 0", hazard);
        end
        two_src = 1;
        #1;
        tests++;
        if (hazard !== 1'b1) begin
            errors++;
            $display("FAIL src2_on got %b want 1", hazard);
        end
        idle();
        tick();
    endtask

    task automatic test_stalls();
        logic [15:0] want;
`ifdef SCOREBOARD_STATS_EN
        want = 16'd10;
`else
        want = 16'd0;
`endif
        do_reset();
        issue(4'd9, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            issue(4'd1, 1, 4'd9, 0, 0);
            tick();
        end
        idle();
        tests++;
        if (stall_cycles !== want) begin
            errors++;
            $display("FAIL stall_count got %0d want %0d", stall_cycles, want);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 79) == 0);
            issue_valid = $urandom_range(0, 3) != 0;
            issue_wb_en = $urandom_range(0, 3) != 0;
            issue_dest  = 4'($urandom_range(0, 7));
            src1        = 4'($urandom_range(0, 7));
            src2        = 4'($urandom_range(0, 7));
            two_src     = 1'($urandom);
            wb_valid    = $urandom_range(0, 2) != 0;
            wb_dest     = 4'($urandom_range(0, 7));
            #1;
            tests++;
            if (hazard !== m_hazard() || issue_ready !== m_ready()) begin
                errors++;
                $display("FAIL rnd_comb@%0d got hz=%b rdy=%b want %b %b",
                         i, hazard, issue_ready, m_hazard(), m_ready());
            end
            tick();
            tests++;
            if (pending_mask !== m_mask() || wb_err !== m_err ||
                stall_cycles !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL rnd_state@%0d got %h/%b/%0d want %h/%b/%0d",
                         i, pending_mask, wb_err, stall_cycles,
                         m_mask(), m_err, m_stalls);
            end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 16; r++) cnt[r] = 0;
        m_err = 0;
        m_stalls = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_basic_hazard();
        test_bypass();
        test_saturation();
        test_wb_err();
        test_two_src();
        test_stalls();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
